// File: rtl/draw_engine_pkg.sv
// Shared constants for the draw engine: op codes, colours, default screen
// geometry and the command FSM encoding.
package draw_pkg;

    localparam logic [1:0] OP_ERASE_BIRD = 2'b00;
    localparam logic [1:0] OP_DRAW_BIRD  = 2'b01;
    localparam logic [1:0] OP_ERASE_WALL = 2'b10;
    localparam logic [1:0] OP_DRAW_WALL  = 2'b11;

    localparam logic [2:0] BG_COLOUR   = 3'b000;
    localparam logic [2:0] BIRD_COLOUR = 3'b110;
    localparam logic [2:0] WALL_COLOUR = 3'b010;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
    localparam int DEF_BIRD_X   = 30;
    localparam int DEF_BIRD_SIZE = 4;
    localparam int DEF_WALL_W   = 8;
    localparam int DEF_GAP_H    = 40;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_BIRD_SCAN = 2'd1,
        S_WALL_SCAN = 2'd2,
        S_FINISH    = 2'd3
    } state_t;

endpackage

// File: rtl/draw_engine_if.sv
// Command handshake from the game controllers plus the VGA adapter write port.
interface draw_engine_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [6:0] bird_y;
    logic [7:0] wall_x;
    logic [6:0] gap_y;
    logic       done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    modport master (
        output req_valid, req_op, bird_y, wall_x, gap_y,
        input  req_ready, done, x, y, colour, plot
    );

    modport slave (
        input  req_valid, req_op, bird_y, wall_x, gap_y,
        output req_ready, done, x, y, colour, plot
    );
endinterface

// File: rtl/draw_engine_pixel_scanner.sv
// Two-level counter: inner wraps at n_inner, outer advances on each inner wrap.
// last flags the final (inner, outer) pair of the sweep.
module pixel_scanner #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         en,
    input  logic [W-1:0] n_inner,
    input  logic [W-1:0] n_outer,
    output logic [W-1:0] inner,
    output logic [W-1:0] outer,
    output logic         last
);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] inner_q, inner_d;
    logic [W-1:0] outer_q, outer_d;
    logic         inner_wrap;

    assign inner_wrap = (inner_q == n_inner - ONE);

    always_comb begin
        inner_d = inner_q;
        outer_d = outer_q;
        if (start) begin
            inner_d = '0;
            outer_d = '0;
        end else if (en) begin
            if (inner_wrap) begin
                inner_d = '0;
                outer_d = (outer_q == n_outer - ONE) ? '0 : outer_q + ONE;
            end else begin
                inner_d = inner_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inner_q <= '0;
            outer_q <= '0;
        end else begin
            inner_q <= inner_d;
            outer_q <= outer_d;
        end
    end

    assign inner = inner_q;
    assign outer = outer_q;
    assign last  = inner_wrap && (outer_q == n_outer - ONE);
endmodule

// File: rtl/draw_engine.sv
// Bird/wall pixel plotter with sticky collision flag.
// Define DRAW_ENGINE_FLOOR_HIT_EN to also flag the bird touching the floor.
module draw_engine
    import draw_pkg::*;
#(
    parameter int SCREEN_W  = DEF_SCREEN_W,
    parameter int SCREEN_H  = DEF_SCREEN_H,
    parameter int BIRD_X    = DEF_BIRD_X,
    parameter int BIRD_SIZE = DEF_BIRD_SIZE,
    parameter int WALL_W    = DEF_WALL_W,
    parameter int GAP_H     = DEF_GAP_H
) (
    input  logic clk,
    input  logic reset,
    draw_engine_if.slave bus,
    input  logic clr_collision,
    output logic collision
);
    localparam logic [8:0] SCR_W9  = 9'(SCREEN_W);
    localparam logic [7:0] SCR_H8  = 8'(SCREEN_H);
    localparam logic [7:0] BIRD_X8 = 8'(BIRD_X);
    localparam logic [8:0] BIRD_X9 = 9'(BIRD_X);
    localparam logic [7:0] BSZ8    = 8'(BIRD_SIZE);
    localparam logic [8:0] BSZ9    = 9'(BIRD_SIZE);
    localparam logic [7:0] WALL_W8 = 8'(WALL_W);
    localparam logic [8:0] WALL_W9 = 9'(WALL_W);
    localparam logic [7:0] GAP_H8  = 8'(GAP_H);

    state_t     state_q, state_d;
    logic       ready_q, ready_d;
    logic       plot_q, plot_d;
    logic       done_q, done_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       collision_q, collision_d;
    logic [1:0] op_q, op_d;
    logic [6:0] bird_y_q, bird_y_d;
    logic [7:0] wall_x_q, wall_x_d;
    logic [6:0] gap_y_q, gap_y_d;
    logic [6:0] sh_bird_y_q, sh_bird_y_d;
    logic [7:0] sh_wall_x_q, sh_wall_x_d;
    logic [6:0] sh_gap_y_q, sh_gap_y_d;

    logic       accept, scanning, in_wall;
    logic [7:0] scan_inner, scan_outer, n_inner, n_outer;
    logic       scan_last;

    assign accept   = bus.req_valid && ready_q;
    assign in_wall  = (state_q == S_WALL_SCAN);
    assign scanning = (state_q == S_BIRD_SCAN) || in_wall;
    // Bird sweeps row-major (inner = column); wall sweeps column-major (inner = row).
    assign n_inner  = in_wall ? SCR_H8 : BSZ8;
    assign n_outer  = in_wall ? WALL_W8 : BSZ8;

    pixel_scanner #(.W(8)) u_scanner (
        .clk     (clk),
        .reset   (reset),
        .start   (accept),
        .en      (scanning),
        .n_inner (n_inner),
        .n_outer (n_outer),
        .inner   (scan_inner),
        .outer   (scan_outer),
        .last    (scan_last)
    );

    logic [7:0] bird_px, bird_row, gap_end;
    logic [8:0] wall_col;
    logic       bird_vis, wall_vis, in_gap;
    logic [2:0] pix_colour;

    assign bird_px  = BIRD_X8 + scan_inner;
    assign bird_row = {1'b0, bird_y_q} + scan_outer;
    assign bird_vis = bird_row < SCR_H8;
    assign wall_col = {1'b0, wall_x_q} + {1'b0, scan_outer};
    assign gap_end  = {1'b0, gap_y_q} + GAP_H8;
    assign in_gap   = (scan_inner >= {1'b0, gap_y_q}) && (scan_inner < gap_end);
    assign wall_vis = (wall_col < SCR_W9) && !in_gap;
    assign pix_colour = !op_q[0] ? BG_COLOUR : (op_q[1] ? WALL_COLOUR : BIRD_COLOUR);

    // Collision uses the positions as they will stand once this command commits.
    logic [6:0] cb_y, cg_y;
    logic [7:0] cw_x, bird_bot, gap_bot;
    logic       x_ovl, out_gap, hit;

    assign cb_y     = (op_q == OP_DRAW_BIRD) ? bird_y_q : sh_bird_y_q;
    assign cw_x     = (op_q == OP_DRAW_WALL) ? wall_x_q : sh_wall_x_q;
    assign cg_y     = (op_q == OP_DRAW_WALL) ? gap_y_q  : sh_gap_y_q;
    assign bird_bot = {1'b0, cb_y} + BSZ8;
    assign gap_bot  = {1'b0, cg_y} + GAP_H8;
    assign x_ovl    = (BIRD_X9 < ({1'b0, cw_x} + WALL_W9)) && ({1'b0, cw_x} < (BIRD_X9 + BSZ9));
    assign out_gap  = (cb_y < cg_y) || (bird_bot > gap_bot);
`ifdef DRAW_ENGINE_FLOOR_HIT_EN
    assign hit = (x_ovl && out_gap) || ((op_q == OP_DRAW_BIRD) && (bird_bot > SCR_H8));
`else
    assign hit = x_ovl && out_gap;
`endif

    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        plot_d      = 1'b0;
        done_d      = 1'b0;
        x_d         = x_q;
        y_d         = y_q;
        colour_d    = colour_q;
        op_d        = op_q;
        bird_y_d    = bird_y_q;
        wall_x_d    = wall_x_q;
        gap_y_d     = gap_y_q;
        sh_bird_y_d = sh_bird_y_q;
        sh_wall_x_d = sh_wall_x_q;
        sh_gap_y_d  = sh_gap_y_q;
        collision_d = clr_collision ? 1'b0 : collision_q;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    ready_d  = 1'b0;
                    op_d     = bus.req_op;
                    bird_y_d = bus.bird_y;
                    wall_x_d = bus.wall_x;
                    gap_y_d  = bus.gap_y;
                    state_d  = bus.req_op[1] ? S_WALL_SCAN : S_BIRD_SCAN;
                end
            end
            S_BIRD_SCAN: begin
                plot_d = bird_vis;
                if (bird_vis) begin
                    x_d      = bird_px;
                    y_d      = bird_row[6:0];
                    colour_d = pix_colour;
                end
                if (scan_last) state_d = S_FINISH;
            end
            S_WALL_SCAN: begin
                plot_d = wall_vis;
                if (wall_vis) begin
                    x_d      = wall_col[7:0];
                    y_d      = scan_inner[6:0];
                    colour_d = pix_colour;
                end
                if (scan_last) state_d = S_FINISH;
            end
            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (op_q == OP_DRAW_BIRD) sh_bird_y_d = bird_y_q;
                if (op_q == OP_DRAW_WALL) begin
                    sh_wall_x_d = wall_x_q;
                    sh_gap_y_d  = gap_y_q;
                end
                if (op_q[0] && hit) collision_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            plot_q      <= 1'b0;
            done_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            colour_q    <= BG_COLOUR;
            collision_q <= 1'b0;
            op_q        <= OP_ERASE_BIRD;
            bird_y_q    <= '0;
            wall_x_q    <= '0;
            gap_y_q     <= '0;
            sh_bird_y_q <= '0;
            sh_wall_x_q <= 8'(SCREEN_W);
            sh_gap_y_q  <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            plot_q      <= plot_d;
            done_q      <= done_d;
            x_q         <= x_d;
            y_q         <= y_d;
            colour_q    <= colour_d;
            collision_q <= collision_d;
            op_q        <= op_d;
            bird_y_q    <= bird_y_d;
            wall_x_q    <= wall_x_d;
            gap_y_q     <= gap_y_d;
            sh_bird_y_q <= sh_bird_y_d;
            sh_wall_x_q <= sh_wall_x_d;
            sh_gap_y_q  <= sh_gap_y_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.plot      = plot_q;
    assign bus.done      = done_q;
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.colour    = colour_q;
    assign collision     = collision_q;
endmodule

// File: tb/tb_draw_engine.sv
// Directed and random commands against a geometric model of the draw engine;
// every plotted pixel, latency, handshake and collision result is checked.
module tb_draw_engine;
    logic clk = 1'b0;
    logic reset;
    logic clr_collision;
    logic collision;

    draw_engine_if bus ();

    draw_engine dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .clr_collision (clr_collision),
        .collision     (collision)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: last drawn positions and collision flag.
    int m_by = 0;
    int m_wx = 160;
    int m_gy = 0;
    bit m_coll = 1'b0;
    logic [17:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
            $error("check %s", tag);
        end
    endtask

    function automatic bit model_hit(int by, int wx, int gy, bit bird_op);
        bit h;
        h = (30 < wx + 8) && (wx < 30 + 4) && ((by < gy) || (by + 4 > gy + 40));
`ifdef DRAW_ENGINE_FLOOR_HIT_EN
        if (bird_op && (by + 4 > 120)) h = 1'b1;
`endif
        return h;
    endfunction

    task automatic build_expect(input logic [1:0] op, input int by, input int wx, input int gy);
        logic [2:0] col;
        col = (op == 2'b01) ? 3'b110 : (op == 2'b11) ? 3'b010 : 3'b000;
        exp_q.delete();
        if (!op[1]) begin
            for (int r = by; r < by + 4; r++)
                for (int c = 30; c < 34; c++)
                    if (r < 120) exp_q.push_back({8'(c), 7'(r), col});
        end else begin
            for (int c = wx; c < wx + 8; c++)
                for (int r = 0; r < 120; r++)
                    if (c < 160 && !(r >= gy && r < gy + 40)) exp_q.push_back({8'(c), 7'(r), col});
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input int by, input int wx, input int gy,
                           input bit hold_clr, input string tag);
        int n_exp, n_pix, plots, done_cyc;
        bit ready_ok;
        build_expect(op, by, wx, gy);
        n_pix = exp_q.size();
        n_exp = op[1] ? 960 : 16;
        bus.req_op    = op;
        bus.bird_y    = 7'(by);
        bus.wall_x    = 8'(wx);
        bus.gap_y     = 7'(gy);
        bus.req_valid = 1'b1;
        clr_collision = hold_clr;
        chk({tag, "_ready_in"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        plots = 0; done_cyc = -1; ready_ok = 1'b1;
        for (int n = 1; n <= 1200; n++) begin
            @(posedge clk); #1;
            if (bus.plot) begin
                plots++;
                if (exp_q.size() != 0) chk({tag, "_pix"}, 32'({bus.x, bus.y, bus.colour}), 32'(exp_q.pop_front()));
            end
            if (bus.done) begin
                done_cyc = n;
                break;
            end
            if (bus.req_ready) ready_ok = 1'b0;
        end
        clr_collision = 1'b0;
        chk({tag, "_plots"}, 32'(plots), 32'(n_pix));
        chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(n_exp + 1));
        chk({tag, "_ready_busy"}, 32'(ready_ok), 32'd1);
        if (op == 2'b01) m_by = by;
        if (op == 2'b11) begin m_wx = wx; m_gy = gy; end
        if (op[0]) begin
            if (hold_clr) m_coll = model_hit(m_by, m_wx, m_gy, op == 2'b01);
            else m_coll = m_coll | model_hit(m_by, m_wx, m_gy, op == 2'b01);
        end
        chk({tag, "_coll"}, 32'(collision), 32'(m_coll));
        @(posedge clk); #1;
        chk({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        $display("cmd %s op=%0d by=%0d wx=%0d gy=%0d plots=%0d done_cyc=%0d coll=%0d",
                 tag, op, by, wx, gy, plots, done_cyc, collision);
    endtask

    task automatic clear_coll();
        clr_collision = 1'b1;
        @(posedge clk); #1;
        clr_collision = 1'b0;
        m_coll = 1'b0;
        chk("clear_coll", 32'(collision), 32'd0);
    endtask

    initial begin
        bit saw_done;
        reset = 1'b1; clr_collision = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.bird_y = '0; bus.wall_x = '0; bus.gap_y = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_plot", 32'(bus.plot), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_coll", 32'(collision), 32'd0);
        chk("rst_x", 32'(bus.x), 32'd0);
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_colour", 32'(bus.colour), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_cmd(2'b01, 50, 0, 0, 1'b0, "bird50");
        clear_coll();
        run_cmd(2'b01, 118, 0, 0, 1'b0, "bird_floor");
`ifdef DRAW_ENGINE_FLOOR_HIT_EN
        chk("floor_coll", 32'(collision), 32'd1);
`else
        chk("floor_coll", 32'(collision), 32'd0);
`endif
        run_cmd(2'b11, 0, 100, 40, 1'b0, "wall100");
        run_cmd(2'b11, 0, 156, 40, 1'b0, "wall156");

        clear_coll();
        run_cmd(2'b01, 10, 0, 0, 1'b0, "bird10");
        run_cmd(2'b11, 0, 28, 40, 1'b0, "wall28_hit");
        chk("coll_hit", 32'(collision), 32'd1);

        clear_coll();
        run_cmd(2'b01, 50, 0, 0, 1'b0, "bird50b");
        run_cmd(2'b11, 0, 28, 40, 1'b0, "wall28_miss");
        chk("coll_miss", 32'(collision), 32'd0);

        run_cmd(2'b01, 10, 0, 0, 1'b0, "bird10b");
        run_cmd(2'b11, 0, 28, 40, 1'b1, "wall28_clr");
        chk("coll_set_wins", 32'(collision), 32'd1);

        // Abort a wall scan with reset at cycle 300.
        bus.req_op = 2'b11; bus.wall_x = 8'd100; bus.gap_y = 7'd40; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (299) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_by = 0; m_wx = 160; m_gy = 0; m_coll = 1'b0;
        chk("abort_plot", 32'(bus.plot), 32'd0);
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_coll", 32'(collision), 32'd0);
        saw_done = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk); #1;
            if (bus.done) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);
        $display("cmd abort done_seen=%0d", saw_done);

        for (int k = 0; k < 12; k++) begin
            run_cmd(2'($urandom_range(0, 3)), int'($urandom_range(0, 127)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), 1'b0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
